// File: rtl/run_continue_ctrl.sv
// Run/Continue front-panel controller: key sync/debounce, strobes, pause LED, combo reset.
// Define RUNCTL_DEBOUNCE_EN to insert the per-key debouncer after the synchronizer.
module run_continue_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic       pause_req,
    input  logic [9:0] pause_code,
    output logic       run_pulse,
    output logic       cont_ack,
    output logic       cpu_reset,
    output logic       paused,
    output logic [9:0] LED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUNNING,
        S_PAUSED,
        S_WAIT_REL,
        S_COMBO
    } state_t;

    // bit 0 = Run key, bit 1 = Continue key; 1 = released
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_deb;
    logic [1:0] r_lvl;
    logic [1:0] r_press;

    state_t     r_state;
    state_t     w_next;
    logic       w_run_pulse;
    logic       w_cont_ack;
    logic       w_load_led;

    logic       r_run_pulse;
    logic       r_cont_ack;
    logic       r_cpu_reset;
    logic       r_paused;
    logic [9:0] r_led;

    assign w_raw = {Continue, Run};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef RUNCTL_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] r_cnt [2];
    logic [1:0]    r_deb;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_deb <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    assign w_deb = r_deb;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (DEBOUNCE_CYCLES > 1);
    assign w_deb        = r_sync2;
`endif

    // Level and press event are aligned so the FSM sees both on one edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lvl   <= 2'b11;
            r_press <= 2'b00;
        end else begin
            r_lvl   <= w_deb;
            r_press <= r_lvl & ~w_deb;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_run_pulse = 1'b0;
        w_cont_ack  = 1'b0;
        w_load_led  = 1'b0;
        if (r_lvl == 2'b00) begin
            w_next = S_COMBO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_press[0]) begin
                        w_run_pulse = 1'b1;
                        w_next      = S_RUNNING;
                    end
                end
                S_RUNNING: begin
                    if (pause_req) begin
                        w_load_led = 1'b1;
                        w_next     = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (r_press[1]) begin
                        w_cont_ack = 1'b1;
                        w_next     = S_WAIT_REL;
                    end
                end
                S_WAIT_REL: begin
                    if (!pause_req && r_lvl[1]) begin
                        w_next = S_RUNNING;
                    end
                end
                S_COMBO: begin
                    if (r_lvl == 2'b11) begin
                        w_next = S_IDLE;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_run_pulse <= 1'b0;
            r_cont_ack  <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_paused    <= 1'b0;
            r_led       <= 10'h000;
        end else begin
            r_state     <= w_next;
            r_run_pulse <= w_run_pulse;
            r_cont_ack  <= w_cont_ack;
            r_cpu_reset <= (w_next == S_COMBO);
            r_paused    <= (w_next == S_PAUSED) || (w_next == S_WAIT_REL);
            if (w_load_led) begin
                r_led <= pause_code;
            end
        end
    end

    assign run_pulse = r_run_pulse;
    assign cont_ack  = r_cont_ack;
    assign cpu_reset = r_cpu_reset;
    assign paused    = r_paused;
    assign LED       = r_led;

endmodule

// File: tb/tb_run_continue_ctrl.sv
// Bench for run_continue_ctrl: window-based key model plus directed front-panel scenarios.
// Builds with or without RUNCTL_DEBOUNCE_EN (debounce length 4 when enabled).
module tb_run_continue_ctrl;

    localparam int D = 4;
`ifdef RUNCTL_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_WAIT   = 3;
    localparam int S_COMBO  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       cont;
    logic       pause_req;
    logic [9:0] pause_code;
    logic       run_pulse;
    logic       cont_ack;
    logic       cpu_reset;
    logic       paused;
    logic [9:0] LED;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_rp   = 0;
    int n_ca   = 0;

    run_continue_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Run       (run),
        .Continue  (cont),
        .pause_req (pause_req),
        .pause_code(pause_code),
        .run_pulse (run_pulse),
        .cont_ack  (cont_ack),
        .cpu_reset (cpu_reset),
        .paused    (paused),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [9:0] act,
                         input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    // Accepted level from raw samples; h[0] is the newest sample
    function automatic bit next_deb(input logic [15:0] h, input bit cur);
`ifdef RUNCTL_DEBOUNCE_EN
        bit v;
        v = h[1];
        for (int i = 1; i <= D; i++) begin
            if (h[i] != v) return cur;
        end
        return v;
`else
        return h[0];
`endif
    endfunction

    logic [15:0] hr;
    logic [15:0] hc;
    bit          mr_deb;
    bit          mc_deb;
    bit          m_lvl_r;
    bit          m_lvl_c;
    bit          m_pr_r;
    bit          m_pr_c;
    int          m_st;
    bit          m_rp;
    bit          m_ca;
    bit          m_cr;
    bit          m_pa;
    logic [9:0]  m_led;
    bit          t_rp;
    bit          t_ca;
    int          t_ns;
    logic [9:0]  t_led;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            hr = '1;
            hc = '1;
            mr_deb = 1; mc_deb = 1;
            m_lvl_r = 1; m_lvl_c = 1;
            m_pr_r = 0; m_pr_c = 0;
            m_st = S_IDLE;
            m_rp = 0; m_ca = 0; m_cr = 0; m_pa = 0;
            m_led = 10'h000;
        end else begin
            t_rp = 0;
            t_ca = 0;
            t_ns = m_st;
            t_led = m_led;
            if (!m_lvl_r && !m_lvl_c) begin
                t_ns = S_COMBO;
            end else begin
                case (m_st)
                    S_IDLE:   if (m_pr_r) begin t_rp = 1; t_ns = S_RUN; end
                    S_RUN:    if (pause_req) begin
                                  t_led = pause_code;
                                  t_ns = S_PAUSED;
                              end
                    S_PAUSED: if (m_pr_c) begin t_ca = 1; t_ns = S_WAIT; end
                    S_WAIT:   if (!pause_req && m_lvl_c) t_ns = S_RUN;
                    default:  if (m_lvl_r && m_lvl_c) t_ns = S_IDLE;
                endcase
            end
            m_rp = t_rp;
            m_ca = t_ca;
            m_cr = (t_ns == S_COMBO);
            m_pa = (t_ns == S_PAUSED) || (t_ns == S_WAIT);
            m_st = t_ns;
            m_led = t_led;
            m_pr_r = m_lvl_r & ~mr_deb;
            m_pr_c = m_lvl_c & ~mc_deb;
            m_lvl_r = mr_deb;
            m_lvl_c = mc_deb;
            mr_deb = next_deb(hr, mr_deb);
            mc_deb = next_deb(hc, mc_deb);
            hr = {hr[14:0], run};
            hc = {hc[14:0], cont};
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("run_pulse", 10'(run_pulse), 10'(m_rp));
            check("cont_ack", 10'(cont_ack), 10'(m_ca));
            check("cpu_reset", 10'(cpu_reset), 10'(m_cr));
            check("paused", 10'(paused), 10'(m_pa));
            check("LED", LED, m_led);
            check("strobe_excl", 10'(run_pulse & cont_ack), 10'h0);
            if (run_pulse) n_rp++;
            if (cont_ack) n_ca++;
        end
    end

    // Return at the negedge following edge e
    task automatic upto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    int ack_e;

    initial begin
        rst = 1; run = 1; cont = 1;
        pause_req = 0; pause_code = 10'h000;
        upto(2);
        check("rst_rp", 10'(run_pulse), 10'h0);
        check("rst_ca", 10'(cont_ack), 10'h0);
        check("rst_cr", 10'(cpu_reset), 10'h0);
        check("rst_pa", 10'(paused), 10'h0);
        check("rst_led", LED, 10'h000);
        rst = 0;

        upto(9);  run = 0;
        upto(10 + LAT - 1);
        check("rp_early", 10'(run_pulse), 10'h0);
        upto(10 + LAT);
        check("rp_edge", 10'(run_pulse), 10'h1);
        upto(10 + LAT + 1);
        check("rp_width", 10'(run_pulse), 10'h0);
        upto(24); run = 1;

        upto(39); pause_req = 1; pause_code = 10'h2A5;
        upto(40);
        check("pause_pa", 10'(paused), 10'h1);
        check("pause_led", LED, 10'h2A5);
        upto(42); pause_code = 10'h0F0;
        upto(45);
        check("led_hold", LED, 10'h2A5);

        upto(49); cont = 0;
        ack_e = 50 + LAT;
        upto(ack_e);
        check("ca_edge", 10'(cont_ack), 10'h1);
        upto(ack_e + 2); pause_req = 0;
        upto(ack_e + 10); pause_req = 1; pause_code = 10'h3C3;
        upto(ack_e + 15); pause_req = 0;
        upto(88);
        check("paused_held", 10'(paused), 10'h1);
        upto(89); cont = 1;
        upto(90 + LAT - 1);
        check("wait_pa", 10'(paused), 10'h1);
        upto(90 + LAT);
        check("resume_pa", 10'(paused), 10'h0);
        check("one_ack", 10'(n_ca), 10'd1);
        check("led_after", LED, 10'h2A5);

        upto(119); run = 0; cont = 0;
        upto(120 + LAT - 1);
        check("combo_early", 10'(cpu_reset), 10'h0);
        upto(120 + LAT);
        check("combo_cr", 10'(cpu_reset), 10'h1);
        upto(139); run = 1; cont = 1;
        upto(140 + LAT - 1);
        check("combo_hold", 10'(cpu_reset), 10'h1);
        upto(140 + LAT);
        check("combo_exit", 10'(cpu_reset), 10'h0);
        check("combo_rp", 10'(n_rp), 10'd1);
        check("combo_ca", 10'(n_ca), 10'd1);

`ifdef RUNCTL_DEBOUNCE_EN
        upto(159); run = 0;
        upto(161); run = 1;
        upto(168);
        check("glitch_rp", 10'(n_rp), 10'd1);
`endif
        upto(169); cont = 0;
        upto(174); cont = 1;
        upto(190);
        check("idle_cont", 10'(n_ca), 10'd1);
        check("idle_rp", 10'(n_rp), 10'd1);

        upto(199); run = 0;
        upto(200 + LAT);
        check("rp2_edge", 10'(run_pulse), 10'h1);
        upto(214); run = 1;
        upto(229); pause_req = 1; pause_code = 10'h155;
        upto(230);
        check("p2_led", LED, 10'h155);
        upto(239); rst = 1;
        upto(240);
        check("rst_p_led", LED, 10'h000);
        check("rst_p_pa", 10'(paused), 10'h0);
        rst = 0; pause_req = 0;

        upto(249); run = 0; cont = 0;
        upto(250 + LAT);
        check("combo2_cr", 10'(cpu_reset), 10'h1);
        upto(264); rst = 1; run = 1; cont = 1;
        upto(265);
        check("rst_combo", 10'(cpu_reset), 10'h0);
        rst = 0;
        upto(290);
        check("final_pa", 10'(paused), 10'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
